// File: rtl/tv80_alu16_seq_if.sv
// Handshake and ALU-side bus of the 16-bit ALU sequencer.
// slave = sequencer side, master = core/ALU environment side.
interface tv80_alu16_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [7:0]  f_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_bus_a;
  logic [7:0]  alu_bus_b;
  logic [7:0]  alu_f_in;
  logic [7:0]  alu_q;
  logic [7:0]  alu_f;

  modport slave (
    input  start, op, opa, opb, f_in, alu_q, alu_f,
    output busy, done, result, f_out,
           alu_op, alu_arith16, alu_z16, alu_bus_a, alu_bus_b, alu_f_in
  );

  modport master (
    output start, op, opa, opb, f_in, alu_q, alu_f,
    input  busy, done, result, f_out,
           alu_op, alu_arith16, alu_z16, alu_bus_a, alu_bus_b, alu_f_in
  );
endinterface

// File: rtl/tv80_alu16_seq.sv
// Runs 16-bit ADD/ADC/SBC HL,rr as two passes (low byte, high byte) on the 8-bit tv80_alu.
// Define TV80_ALU16_SEQ_CP16_EN to accept op=11 as a 16-bit compare (flags only).
//
// state | meaning
// IDLE  | waiting for start; alu_* outputs held at 0
// LO    | low-byte pass on the ALU
// HI    | high-byte pass, Z and carry chained through lo_f
module tv80_alu16_seq #(
  parameter int FLAG_C = 0,
  parameter int FLAG_Z = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  tv80_alu16_seq_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SBC = 2'b10;
  localparam logic [1:0] OP_CP  = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [7:0]  fin_q, fin_d;
  logic [7:0]  lo_res_q, lo_res_d;
  logic [7:0]  lo_f_q, lo_f_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  f_out_q, f_out_d;
  logic        done_q, done_d;
  logic        op_legal;

  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_bus_a;
  logic [7:0]  alu_bus_b;
  logic [7:0]  alu_f_in;

`ifdef TV80_ALU16_SEQ_CP16_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = (bus.op != OP_CP);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      opa_q    <= 16'h0000;
      opb_q    <= 16'h0000;
      fin_q    <= 8'h00;
      lo_res_q <= 8'h00;
      lo_f_q   <= 8'h00;
      result_q <= 16'h0000;
      f_out_q  <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      fin_q    <= fin_d;
      lo_res_q <= lo_res_d;
      lo_f_q   <= lo_f_d;
      result_q <= result_d;
      f_out_q  <= f_out_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    fin_d    = fin_q;
    lo_res_d = lo_res_q;
    lo_f_d   = lo_f_q;
    result_d = result_q;
    f_out_d  = f_out_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && op_legal) begin
          op_d    = bus.op;
          opa_d   = bus.opa;
          opb_d   = bus.opb;
          fin_d   = bus.f_in;
          state_d = LO;
        end
      end
      LO: begin
        lo_res_d = bus.alu_q;
        lo_f_d   = bus.alu_f;
        state_d  = HI;
      end
      HI: begin
        // a compare only reports flags; the previous result stays visible
        if (op_q != OP_CP) result_d = {bus.alu_q, lo_res_q};
        f_out_d = bus.alu_f;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_op      = 4'b0000;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    alu_bus_a   = 8'h00;
    alu_bus_b   = 8'h00;
    alu_f_in    = 8'h00;
    case (state_q)
      LO: begin
        alu_bus_a   = opa_q[7:0];
        alu_bus_b   = opb_q[7:0];
        alu_f_in    = fin_q;
        alu_arith16 = (op_q == OP_ADD);
        case (op_q)
          OP_ADD:  alu_op = 4'b0000;
          OP_ADC:  alu_op = 4'b0001;
          OP_SBC:  alu_op = 4'b0011;
          default: alu_op = 4'b0010;
        endcase
      end
      HI: begin
        alu_bus_a   = opa_q[15:8];
        alu_bus_b   = opb_q[15:8];
        alu_f_in    = lo_f_q;
        alu_arith16 = (op_q == OP_ADD);
        alu_z16     = (op_q != OP_ADD);
        alu_op      = (op_q == OP_ADD || op_q == OP_ADC) ? 4'b0001 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.f_out       = f_out_q;
  assign bus.alu_op      = alu_op;
  assign bus.alu_arith16 = alu_arith16;
  assign bus.alu_z16     = alu_z16;
  assign bus.alu_bus_a   = alu_bus_a;
  assign bus.alu_bus_b   = alu_bus_b;
  assign bus.alu_f_in    = alu_f_in;

  // ADD HL,rr must keep Z from f_in and carry out of bit 15
  logic [16:0] add_sum_chk;
  assign add_sum_chk = {1'b0, opa_q} + {1'b0, opb_q};

  a_add_flags: assert property (@(posedge clk) disable iff (reset)
    (done_q && op_q == OP_ADD) |->
      (f_out_q[FLAG_Z] == fin_q[FLAG_Z] && f_out_q[FLAG_C] == add_sum_chk[16]));

endmodule

// File: doc/tv80_alu16_seq.md
Name: tv80_alu16_seq

Overview:
- Multi-cycle sequencer that runs 16-bit ADD/ADC/SBC (HL,rr class) on the shared 8-bit tv80_alu, low byte then high byte.
- Drives the ALU's op/control/bus/flag inputs and captures Q/F_Out each pass.
- Returns a 16-bit result plus Z80-correct flags with a start/busy/done handshake.
- Sits between the core's microcode sequencer and the ALU instance.

Parameters:
- FLAG_C, 0, carry bit index in F.
- FLAG_Z, 6, zero bit index in F; used only for documentation/assertions, since the ALU owns flag math.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  2  00=ADD, 01=ADC, 10=SBC, 11=CP16 (optional) or reserved
- opa  input  16  first operand (HL)
- opb  input  16  second operand (rr)
- f_in  input  8  flags register at start
- busy  output  1  high in LO and HI states
- done  output  1  one-cycle pulse; result/f_out valid
- result  output  16  registered result, held until next completed op
- f_out  output  8  registered flags, held like result
- alu_op  output  4  to ALU ALU_Op
- alu_arith16  output  1  to ALU Arith16
- alu_z16  output  1  to ALU Z16
- alu_bus_a  output  8  to ALU BusA
- alu_bus_b  output  8  to ALU BusB
- alu_f_in  output  8  to ALU F_In
- alu_q  input  8  from ALU Q
- alu_f  input  8  from ALU F_Out

Behaviour:
- Reset values:
  - state=IDLE; busy, done = 0; result = 16'h0000; f_out = 8'h00.
  - All alu_* outputs 0; internal operand/flag latches 0.
- States IDLE -> LO -> HI -> IDLE.
- IDLE:
  - On start=1 with a legal op, latch opa, opb, f_in and op; go to LO.
  - Illegal op (11 without the macro): ignored, state stays IDLE, no done.
- LO (one cycle):
  - alu_bus_a = opa[7:0], alu_bus_b = opb[7:0], alu_f_in = latched f_in.
  - At the clock edge, capture alu_q into lo_q and alu_f into lo_f; go to HI.
- HI (one cycle):
  - alu_bus_a = opa[15:8], alu_bus_b = opb[15:8], alu_f_in = lo_f.
  - At the clock edge: result <= {alu_q, lo_q}, f_out <= alu_f, done <= 1; go to IDLE.
- Op mapping (LO alu_op / HI alu_op, arith16, z16 in HI):
  - ADD: 0000 / 0001, arith16=1 in both passes, z16=0 (S, Z, P preserved from f_in).
  - ADC: 0001 / 0001, arith16=0, z16=1 in HI only.
  - SBC: 0011 / 0011, arith16=0, z16=1 in HI only.
- z16 is 0 in LO, so Z from the low byte chains through lo_f into the HI pass.
- alu_* outputs are decoded from state and latches. They return to 0 in IDLE.
- Latency:
  - start sampled at edge 0.
  - done high during the cycle after edge 2.
  - done deasserts at edge 3 unless a new op completes.
- A start during the done cycle is accepted (state is IDLE), giving back-to-back ops at one per 3 cycles.
- start while busy=1 is ignored; latches are unchanged.
- Reset mid-operation: abort immediately to reset values; no done is produced.
- X/Y flags come from the high byte, as the HI pass produces them.

Optional Feature:
- Macro: TV80_ALU16_SEQ_CP16_EN.
- When defined, op=11 is a 16-bit compare:
  - LO alu_op=0010, HI alu_op=0011, z16=1 in HI, arith16=0.
  - f_out updates and done pulses; result is NOT updated and holds its previous value.
- When undefined, op=11 is rejected in IDLE: no state change, no done.

Test Plan:
- ADD: opa=0x1234, opb=0x0FFF, f_in=0xC5 -> done after 3 edges; result=0x2233; f_out=0xF4 (S, Z, P kept; H=1; C=0).
- ADC: opa=0xFFFF, opb=0x0001, f_in=0x01 -> result=0x0001; f_out=0x11 (C=1, H=1, Z=0 via z16 chaining).
- SBC: opa=0x1000, opb=0x1000, f_in=0x00 -> result=0x0000, f_out=0x42. Then opa=0x0000, opb=0x0001, f_in=0x00 -> result=0xFFFF, f_out=0xBB.
- Handshake:
  - Pulse start during LO with different operands -> ignored; first result unchanged.
  - Start asserted on the done cycle -> second op completes 3 cycles later.
  - op=11 without the macro -> busy stays 0, no done.
- Reset: assert reset during HI -> busy, done, result, f_out and alu_* all 0 immediately (asynchronously); next op runs normally.
- With TV80_ALU16_SEQ_CP16_EN: prior result 0x2233; CP16 opa=0x0005, opb=0x0005 -> f_out Z=1, N=1, C=0; result still 0x2233.
